// File: rtl/conv_pix_ingress.sv
// Ingress framer in front of the convolution line buffer. It counts columns, flags EOL,
// pads lines cut short by an early SOF, drops pre-SOF pixels, and inserts idle gaps after EOL.
package conv_pkg;
  localparam int unsigned PIX_W = 8;
  typedef logic [PIX_W-1:0] pixel_t;
endpackage

module conv_pix_ingress
  import conv_pkg::*;
#(
  parameter int unsigned LINE_W  = 64,
  parameter int unsigned EOL_GAP = 0,
  parameter pixel_t      PAD_VAL = '0
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             in_vld_i,
  input  logic [PIX_W-1:0] in_dat_i,
  input  logic             in_sof_i,
  output logic             in_rdy_o,
  output logic             pixel_vld_o,
  output logic [PIX_W-1:0] pixel_dat_o,
  output logic             pixel_eol_o,
  output logic [1:0]       err_o,
  input  logic             err_clr_i
);

  localparam int unsigned CW = $clog2(LINE_W);
  localparam int unsigned GW = (EOL_GAP > 1) ? $clog2(EOL_GAP) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(LINE_W - 1);
  localparam logic [GW-1:0] GAP_LAST = (EOL_GAP > 0) ? GW'(EOL_GAP - 1) : '0;
  localparam bit HAS_GAP = (EOL_GAP > 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LINE   = 3'd1,
    S_PAD    = 3'd2,
    S_GAP    = 3'd3,
    S_REPLAY = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic            hold_vld_q, hold_vld_d;
  logic [PIX_W-1:0] hold_dat_q, hold_dat_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic            in_rdy_q, in_rdy_d;
  logic            pixel_vld_q, pixel_vld_d;
  logic [PIX_W-1:0] pixel_dat_q, pixel_dat_d;
  logic            pixel_eol_q, pixel_eol_d;
  logic [1:0]      err_q, err_d;
  logic [1:0]      err_set;

  logic xfer;
  logic col_last;
  logic gap_last;

  assign xfer     = in_vld_i & in_rdy_q;
  assign col_last = (col_q == COL_LAST);
  assign gap_last = (gap_cnt_q == GAP_LAST);

  // State and datapath registers
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q     <= S_IDLE;
      col_q       <= '0;
      hold_vld_q  <= 1'b0;
      hold_dat_q  <= '0;
      gap_cnt_q   <= '0;
      in_rdy_q    <= 1'b0;
      pixel_vld_q <= 1'b0;
      pixel_dat_q <= '0;
      pixel_eol_q <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      hold_vld_q  <= hold_vld_d;
      hold_dat_q  <= hold_dat_d;
      gap_cnt_q   <= gap_cnt_d;
      in_rdy_q    <= in_rdy_d;
      pixel_vld_q <= pixel_vld_d;
      pixel_dat_q <= pixel_dat_d;
      pixel_eol_q <= pixel_eol_d;
      err_q       <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (xfer && in_sof_i) state_d = S_LINE;
      end
      S_LINE: begin
        if (xfer) begin
          if (in_sof_i && (col_q != '0)) state_d = S_PAD;
          else if (col_last)             state_d = HAS_GAP ? S_GAP : S_LINE;
        end
      end
      S_PAD: begin
        if (col_last) state_d = HAS_GAP ? S_GAP : S_REPLAY;
      end
      S_GAP: begin
        if (gap_last) state_d = hold_vld_q ? S_REPLAY : S_LINE;
      end
      S_REPLAY: state_d = S_LINE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Emit, column, hold and error updates
  always_comb begin
    col_d       = col_q;
    hold_vld_d  = hold_vld_q;
    hold_dat_d  = hold_dat_q;
    gap_cnt_d   = gap_cnt_q;
    pixel_vld_d = 1'b0;
    pixel_dat_d = pixel_dat_q;
    pixel_eol_d = 1'b0;
    err_set     = 2'b00;
    in_rdy_d    = (state_d == S_IDLE) || (state_d == S_LINE);
    unique case (state_q)
      S_IDLE: begin
        if (xfer) begin
          if (in_sof_i) begin
            pixel_vld_d = 1'b1;
            pixel_dat_d = in_dat_i;
            col_d       = CW'(1);
          end else begin
            err_set[0] = 1'b1;
          end
        end
      end
      S_LINE: begin
        if (xfer) begin
          if (!in_sof_i || (col_q == '0)) begin
            pixel_vld_d = 1'b1;
            pixel_dat_d = in_dat_i;
            if (col_last) begin
              pixel_eol_d = 1'b1;
              col_d       = '0;
              gap_cnt_d   = '0;
            end else begin
              col_d = col_q + CW'(1);
            end
          end else begin
            // Early SOF: park the pixel until the truncated line is padded out
            hold_vld_d = 1'b1;
            hold_dat_d = in_dat_i;
            err_set[1] = 1'b1;
          end
        end
      end
      S_PAD: begin
        pixel_vld_d = 1'b1;
        pixel_dat_d = PAD_VAL;
        if (col_last) begin
          pixel_eol_d = 1'b1;
          col_d       = '0;
          gap_cnt_d   = '0;
        end else begin
          col_d = col_q + CW'(1);
        end
      end
      S_GAP: begin
        gap_cnt_d = gap_cnt_q + GW'(1);
      end
      S_REPLAY: begin
        pixel_vld_d = 1'b1;
        pixel_dat_d = hold_dat_q;
        col_d       = CW'(1);
        hold_vld_d  = 1'b0;
      end
      default: ;
    endcase
    err_d = (err_q & ~{2{err_clr_i}}) | err_set;
  end

  assign in_rdy_o    = in_rdy_q;
  assign pixel_vld_o = pixel_vld_q;
  assign pixel_dat_o = pixel_dat_q;
  assign pixel_eol_o = pixel_eol_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_conv_pix_ingress.sv
// Bench for conv_pix_ingress: two instances (no gap / gap of 2) checked against a
// stream-level model that rebuilds the expected output from the accepted pixels.
module tb_conv_pix_ingress;
  import conv_pkg::*;

  localparam int unsigned LW = 4;
  localparam pixel_t PADV = 8'hA5;

  logic   clk = 1'b0;
  logic   arst;
  logic   vld_i [2];
  logic   sof_i [2];
  logic   clr_i [2];
  pixel_t dat_i [2];
  logic   rdy_o [2];
  logic   pvld_o[2];
  logic   peol_o[2];
  pixel_t pdat_o[2];
  logic [1:0] err_o[2];

  int checks = 0;
  int errors = 0;

  logic [8:0] acc0[$], acc1[$], obs0[$], obs1[$];
  logic [2:0] log1[$];

  always #5 clk = ~clk;

  conv_pix_ingress #(.LINE_W(LW), .EOL_GAP(0), .PAD_VAL(PADV)) u0 (
    .clk(clk), .arst(arst), .in_vld_i(vld_i[0]), .in_dat_i(dat_i[0]), .in_sof_i(sof_i[0]),
    .in_rdy_o(rdy_o[0]), .pixel_vld_o(pvld_o[0]), .pixel_dat_o(pdat_o[0]),
    .pixel_eol_o(peol_o[0]), .err_o(err_o[0]), .err_clr_i(clr_i[0]));

  conv_pix_ingress #(.LINE_W(LW), .EOL_GAP(2), .PAD_VAL(PADV)) u1 (
    .clk(clk), .arst(arst), .in_vld_i(vld_i[1]), .in_dat_i(dat_i[1]), .in_sof_i(sof_i[1]),
    .in_rdy_o(rdy_o[1]), .pixel_vld_o(pvld_o[1]), .pixel_dat_o(pdat_o[1]),
    .pixel_eol_o(peol_o[1]), .err_o(err_o[1]), .err_clr_i(clr_i[1]));

  // Record accepted inputs and emitted pixels at the falling edge
  always @(negedge clk) begin
    if (!arst) begin
      if (vld_i[0] && rdy_o[0]) acc0.push_back({sof_i[0], dat_i[0]});
      if (pvld_o[0])            obs0.push_back({peol_o[0], pdat_o[0]});
      if (vld_i[1] && rdy_o[1]) acc1.push_back({sof_i[1], dat_i[1]});
      if (pvld_o[1])            obs1.push_back({peol_o[1], pdat_o[1]});
      log1.push_back({rdy_o[1], pvld_o[1], peol_o[1]});
    end
  end

  // Expected output stream from the accepted pixels: frame/column bookkeeping only
  task automatic model_run(input logic [8:0] acc[$], output logic [8:0] ex[$], output logic [1:0] e);
    bit     infr;
    int     col;
    logic   s;
    pixel_t d;
    infr = 0; col = 0; e = 2'b00; ex = {};
    foreach (acc[i]) begin
      s = acc[i][8];
      d = acc[i][7:0];
      if (!infr && !s) begin
        e[0] = 1'b1;
        continue;
      end
      infr = 1;
      if (s && col != 0) begin
        e[1] = 1'b1;
        while (col != 0) begin
          ex.push_back({(col == LW - 1), PADV});
          col = (col + 1) % LW;
        end
      end
      ex.push_back({(col == LW - 1), d});
      col = (col + 1) % LW;
    end
  endtask

  task automatic step(input int k, input logic v, input pixel_t d, input logic s, input logic c);
    @(posedge clk);
    #1;
    vld_i[k] = v; dat_i[k] = d; sof_i[k] = s; clr_i[k] = c;
    @(negedge clk);
  endtask

  // Hold the pixel until it is accepted at the coming edge
  task automatic send(input int k, input pixel_t d, input logic s);
    int n;
    n = 0;
    step(k, 1'b1, d, s, 1'b0);
    while (rdy_o[k] !== 1'b1 && n < 20) begin
      step(k, 1'b1, d, s, 1'b0);
      n++;
    end
    if (rdy_o[k] !== 1'b1) begin
      checks++; errors++;
      $display("FAIL send_timeout inst%0d: ready never rose, got %b expected 1", k, rdy_o[k]);
    end
  endtask

  task automatic do_reset();
    for (int k = 0; k < 2; k++) begin
      vld_i[k] = 0; sof_i[k] = 0; clr_i[k] = 0; dat_i[k] = '0;
    end
    arst = 1'b1;
    repeat (2) @(posedge clk);
    #1 arst = 1'b0;
    acc0.delete(); acc1.delete(); obs0.delete(); obs1.delete(); log1.delete();
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({rdy_o[k], pvld_o[k], peol_o[k], err_o[k]} !== 5'b0) begin
        errors++;
        $display("FAIL reset_outputs inst%0d: got %b expected 00000", k,
                 {rdy_o[k], pvld_o[k], peol_o[k], err_o[k]});
      end
    end
    do_reset();
    checks++;
    if (rdy_o[0] !== 1'b0) begin
      errors++; $display("FAIL rdy_before_edge: got %b expected 0", rdy_o[0]);
    end
    step(0, 1'b0, '0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (rdy_o[k] !== 1'b1) begin
        errors++; $display("FAIL rdy_after_edge inst%0d: got %b expected 1", k, rdy_o[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] ex[$];
    logic [1:0] e;
    logic       prev;
    do_reset();
    step(0, 1'b0, '0, 1'b0, 1'b0);
    prev = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) step(0, 1'b1, pixel_t'($urandom), (i == 0), 1'b0);
      else       step(0, 1'b0, '0, 1'b0, 1'b0);
      checks++;
      if (pvld_o[0] !== prev) begin
        errors++; $display("FAIL b2b_latency cyc%0d: got vld %b expected %b", i, pvld_o[0], prev);
      end
      if (i < 8) begin
        checks++;
        if (rdy_o[0] !== 1'b1) begin
          errors++; $display("FAIL b2b_rdy cyc%0d: got %b expected 1", i, rdy_o[0]);
        end
      end
      prev = vld_i[0] & rdy_o[0];
    end
    model_run(acc0, ex, e);
    checks++;
    if (obs0.size() != 8 || ex.size() != 8) begin
      errors++; $display("FAIL b2b_count: got %0d expected %0d", obs0.size(), ex.size());
    end
    for (int i = 0; i < ex.size(); i++) begin
      checks++;
      if (i >= obs0.size() || obs0[i] !== ex[i]) begin
        errors++; $display("FAIL b2b_pix%0d: got %h expected %h", i, (i < obs0.size()) ? obs0[i] : 9'h1ff, ex[i]);
      end
    end
    checks++;
    if (err_o[0] !== 2'b00) begin
      errors++; $display("FAIL b2b_err: got %b expected 00", err_o[0]);
    end
  endtask

  task automatic test_pre_sof();
    logic [8:0] ex[$];
    logic [1:0] e;
    pixel_t     sp;
    do_reset();
    for (int i = 0; i < 3; i++) send(0, pixel_t'($urandom), 1'b0);
    sp = pixel_t'($urandom);
    send(0, sp, 1'b1);
    send(0, pixel_t'($urandom), 1'b0);
    send(0, pixel_t'($urandom), 1'b0);
    repeat (2) step(0, 1'b0, '0, 1'b0, 1'b0);
    model_run(acc0, ex, e);
    checks++;
    if (err_o[0] !== 2'b01 || e !== 2'b01) begin
      errors++; $display("FAIL presof_err: got %b expected 01", err_o[0]);
    end
    checks++;
    if (obs0.size() == 0 || obs0[0] !== {1'b0, sp}) begin
      errors++; $display("FAIL presof_first: got %h expected %h", (obs0.size() > 0) ? obs0[0] : 9'h1ff, {1'b0, sp});
    end
    checks++;
    if (obs0.size() != ex.size()) begin
      errors++; $display("FAIL presof_count: got %0d expected %0d", obs0.size(), ex.size());
    end
    for (int i = 0; i < ex.size(); i++) begin
      checks++;
      if (i >= obs0.size() || obs0[i] !== ex[i]) begin
        errors++; $display("FAIL presof_pix%0d: got %h expected %h", i, (i < obs0.size()) ? obs0[i] : 9'h1ff, ex[i]);
      end
    end
  endtask

  task automatic test_early_sof();
    logic [8:0] ex[$];
    logic [1:0] e;
    pixel_t     sp;
    int         n;
    do_reset();
    send(0, pixel_t'($urandom), 1'b1);
    send(0, pixel_t'($urandom), 1'b0);
    sp = pixel_t'($urandom);
    send(0, sp, 1'b1);
    n = 0;
    step(0, 1'b0, '0, 1'b0, 1'b0);
    while (rdy_o[0] === 1'b0 && n < 10) begin
      n++;
      step(0, 1'b0, '0, 1'b0, 1'b0);
    end
    checks++;
    if (n != 3) begin
      errors++; $display("FAIL early_rdy_low: got %0d cycles expected 3", n);
    end
    send(0, pixel_t'($urandom), 1'b0);
    send(0, pixel_t'($urandom), 1'b0);
    repeat (2) step(0, 1'b0, '0, 1'b0, 1'b0);
    model_run(acc0, ex, e);
    checks++;
    if (err_o[0] !== 2'b10 || e !== 2'b10) begin
      errors++; $display("FAIL early_err: got %b expected 10", err_o[0]);
    end
    checks++;
    if (obs0.size() < 5 || obs0[3] !== {1'b1, PADV} || obs0[4] !== {1'b0, sp}) begin
      errors++; $display("FAIL early_pad_replay: got %h %h expected %h %h",
                         (obs0.size() > 3) ? obs0[3] : 9'h1ff, (obs0.size() > 4) ? obs0[4] : 9'h1ff,
                         {1'b1, PADV}, {1'b0, sp});
    end
    checks++;
    if (obs0.size() != ex.size()) begin
      errors++; $display("FAIL early_count: got %0d expected %0d", obs0.size(), ex.size());
    end
    for (int i = 0; i < ex.size(); i++) begin
      checks++;
      if (i >= obs0.size() || obs0[i] !== ex[i]) begin
        errors++; $display("FAIL early_pix%0d: got %h expected %h", i, (i < obs0.size()) ? obs0[i] : 9'h1ff, ex[i]);
      end
    end
  endtask

  task automatic test_gap();
    logic [8:0] ex[$];
    logic [1:0] e;
    int         neol;
    logic [2:0] vs, rs;
    do_reset();
    for (int i = 0; i < 10; i++) send(1, pixel_t'($urandom), (i == 0));
    repeat (4) step(1, 1'b0, '0, 1'b0, 1'b0);
    neol = 0;
    for (int c = 0; c + 3 < log1.size(); c++) begin
      if (log1[c][1] && log1[c][0]) begin
        neol++;
        vs = {log1[c+1][1], log1[c+2][1], log1[c+3][1]};
        rs = {log1[c][2], log1[c+1][2], log1[c+2][2]};
        checks++;
        if (vs !== 3'b001 || rs !== 3'b001) begin
          errors++; $display("FAIL gap_after_eol%0d: got vld %b rdy %b expected 001 001", neol, vs, rs);
        end
      end
    end
    checks++;
    if (neol != 2) begin
      errors++; $display("FAIL gap_eol_count: got %0d expected 2", neol);
    end
    model_run(acc1, ex, e);
    checks++;
    if (obs1.size() != 10 || ex.size() != 10) begin
      errors++; $display("FAIL gap_count: got %0d expected %0d", obs1.size(), ex.size());
    end
    for (int i = 0; i < ex.size(); i++) begin
      checks++;
      if (i >= obs1.size() || obs1[i] !== ex[i]) begin
        errors++; $display("FAIL gap_pix%0d: got %h expected %h", i, (i < obs1.size()) ? obs1[i] : 9'h1ff, ex[i]);
      end
    end
  endtask

  task automatic test_reset_mid_pad();
    logic [8:0] ex[$];
    logic [1:0] e;
    do_reset();
    send(0, pixel_t'($urandom), 1'b1);
    send(0, pixel_t'($urandom), 1'b0);
    send(0, pixel_t'($urandom), 1'b1);
    step(0, 1'b0, '0, 1'b0, 1'b0);
    checks++;
    if (obs0.size() != 2 || obs0[0][8] !== 1'b0 || obs0[1][8] !== 1'b0) begin
      errors++; $display("FAIL midpad_pre: got %0d pixels expected 2 without eol", obs0.size());
    end
    #1 arst = 1'b1;
    #1;
    checks++;
    if ({rdy_o[0], pvld_o[0], peol_o[0], err_o[0]} !== 5'b0) begin
      errors++; $display("FAIL midpad_async: got %b expected 00000", {rdy_o[0], pvld_o[0], peol_o[0], err_o[0]});
    end
    do_reset();
    send(0, pixel_t'($urandom), 1'b1);
    for (int i = 0; i < 3; i++) send(0, pixel_t'($urandom), 1'b0);
    repeat (3) step(0, 1'b0, '0, 1'b0, 1'b0);
    model_run(acc0, ex, e);
    checks++;
    if (obs0.size() != 4 || err_o[0] !== 2'b00) begin
      errors++; $display("FAIL midpad_restart: got %0d pixels err %b expected 4 err 00", obs0.size(), err_o[0]);
    end
    for (int i = 0; i < ex.size(); i++) begin
      checks++;
      if (i >= obs0.size() || obs0[i] !== ex[i]) begin
        errors++; $display("FAIL midpad_pix%0d: got %h expected %h", i, (i < obs0.size()) ? obs0[i] : 9'h1ff, ex[i]);
      end
    end
  endtask

  task automatic test_err_clr();
    do_reset();
    step(0, 1'b0, '0, 1'b0, 1'b0);
    step(0, 1'b1, pixel_t'($urandom), 1'b0, 1'b1);
    step(0, 1'b0, '0, 1'b0, 1'b0);
    checks++;
    if (err_o[0] !== 2'b01) begin
      errors++; $display("FAIL errclr_set_wins: got %b expected 01", err_o[0]);
    end
    step(0, 1'b0, '0, 1'b0, 1'b1);
    step(0, 1'b0, '0, 1'b0, 1'b0);
    checks++;
    if (err_o[0] !== 2'b00) begin
      errors++; $display("FAIL errclr_clear: got %b expected 00", err_o[0]);
    end
    step(0, 1'b1, pixel_t'($urandom), 1'b0, 1'b0);
    repeat (3) step(0, 1'b0, '0, 1'b0, 1'b0);
    checks++;
    if (err_o[0] !== 2'b01 || obs0.size() != 0) begin
      errors++; $display("FAIL errclr_sticky: got err %b pixels %0d expected 01 0", err_o[0], obs0.size());
    end
  endtask

  initial begin
    arst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      vld_i[k] = 0; sof_i[k] = 0; clr_i[k] = 0; dat_i[k] = '0;
    end
    test_reset();
    test_back_to_back();
    test_pre_sof();
    test_early_sof();
    test_gap();
    test_reset_mid_pad();
    test_err_clr();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
